lcd_time_display: RTL and testbench

- Downstream consumer of the clock/timer core. Takes its time registers, mode and run flag, and drives the DE2 HD44780 16x2 character LCD.
- Owns power-up initialisation and byte-write timing.
- Rewrites both LCD lines whenever any displayed input changes.
- Write-only: LCD_RW is tied low and the data bus is never tri-stated.

---
 rtl/lcd_pkg.sv | 57 +++++
 rtl/lcd_time_display_if.sv | 16 +
 rtl/lcd_write_engine.sv | 109 ++++++++++
 rtl/lcd_time_display.sv | 229 ++++++++++++++++++++++
 tb/tb_lcd_time_display.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command/ASCII constants, sequencer state type and digit helper.
// Revision: 1.0
`default_nettype none

package lcd_pkg;

  localparam logic [7:0] CMD_FUNC  = 8'h38;
  localparam logic [7:0] CMD_DISP  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_CLR   = 8'h01;
  localparam logic [7:0] CMD_L1    = 8'h80;
  localparam logic [7:0] CMD_L2    = 8'hC0;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  localparam logic [31:0] TAG_CLK = "CLK ";
  localparam logic [31:0] TAG_TMR = "TMR ";
  localparam logic [31:0] TAG_SET = "SET ";
  localparam logic [31:0] TAG_UNK = "??? ";

  localparam logic [47:0] L2_RUN   = "RUN   ";
  localparam logic [47:0] L2_STOP  = "STOP  ";
  localparam logic [47:0] L2_ADJ   = "ADJUST";
  localparam logic [47:0] L2_BLANK = "      ";

  localparam logic [5:0] INIT_LAST  = 6'd3;
  localparam logic [5:0] FRAME_LAST = 6'd33;

  typedef enum logic [1:0] {
    ST_PWRUP = 2'd0,
    ST_INIT  = 2'd1,
    ST_IDLE  = 2'd2,
    ST_FRAME = 2'd3
  } top_state_e;

  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       running;
  } snap_t;

  // Out-of-range values (e.g. 63) are rendered literally, never clamped.
  function automatic logic [15:0] bin2ascii2(input logic [5:0] v);
    logic [5:0] tens;
    logic [5:0] ones;
    tens = v / 6'd10;
    ones = v - (tens * 6'd10);
    return {CH_ZERO + {2'b00, tens}, CH_ZERO + {2'b00, ones}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_time_display_if.sv
// lcd_time_display_if: byte-write handshake between the sequencer and the write engine.
// Revision: 1.0
`default_nettype none

interface lcd_time_display_if;
  logic       start;
  logic       rs;
  logic [7:0] data;
  logic       long_wait;
  logic       done;

  modport master (output start, output rs, output data, output long_wait, input done);
  modport slave  (input start, input rs, input data, input long_wait, output done);
endinterface

`default_nettype wire

// File: rtl/lcd_write_engine.sv
// lcd_write_engine: one HD44780 byte write (setup, EN pulse, hold, execution wait).
// Revision: 1.0
`default_nettype none

module lcd_write_engine #(
  parameter int AS_CYC   = 2,
  parameter int EN_CYC   = 25,
  parameter int EXEC_CYC = 2500,
  parameter int CLR_CYC  = 100000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  lcd_time_display_if.slave wr,
  output logic             lcd_en_o,
  output logic             lcd_rs_o,
  output logic [7:0]       lcd_data_o
);

  localparam int MAX_A = (AS_CYC > EN_CYC) ? AS_CYC : EN_CYC;
  localparam int MAX_B = (EXEC_CYC > CLR_CYC) ? EXEC_CYC : CLR_CYC;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    E_IDLE  = 3'd0,
    E_SETUP = 3'd1,
    E_PULSE = 3'd2,
    E_HOLD  = 3'd3,
    E_WAIT  = 3'd4
  } eng_state_e;

  eng_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] w_last;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          long_q, long_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= E_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    w_last = '0;
    case (state_q)
      E_SETUP, E_HOLD: w_last = CW'(AS_CYC - 1);
      E_PULSE:         w_last = CW'(EN_CYC - 1);
      E_WAIT:          w_last = long_q ? CW'(CLR_CYC - 1) : CW'(EXEC_CYC - 1);
      default:         w_last = '0;
    endcase
  end

  // RS/DATA are only captured in E_IDLE, so they stay frozen through EN and hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    long_d  = long_q;
    wr.done = 1'b0;
    case (state_q)
      E_IDLE: begin
        if (wr.start) begin
          rs_d    = wr.rs;
          data_d  = wr.data;
          long_d  = wr.long_wait;
          cnt_d   = '0;
          state_d = E_SETUP;
        end
      end
      E_SETUP, E_PULSE, E_HOLD, E_WAIT: begin
        if (cnt_q == w_last) begin
          cnt_d = '0;
          case (state_q)
            E_SETUP: state_d = E_PULSE;
            E_PULSE: state_d = E_HOLD;
            E_HOLD:  state_d = E_WAIT;
            default: begin
              state_d = E_IDLE;
              wr.done = 1'b1;
            end
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = E_IDLE;
    endcase
  end

  assign lcd_en_o   = (state_q == E_PULSE);
  assign lcd_rs_o   = rs_q;
  assign lcd_data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/lcd_time_display.sv
// lcd_time_display: power-up/init sequencer and two-line time/mode renderer for a 16x2 LCD.
// Revision: 1.0
`default_nettype none

module lcd_time_display
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC = 750000,
  parameter int AS_CYC    = 2,
  parameter int EN_CYC    = 25,
  parameter int EXEC_CYC  = 2500,
  parameter int CLR_CYC   = 100000
) (
  input  wire logic       CLOCK_50,
  input  wire logic       reset,
  input  wire logic [4:0] clock_hours,
  input  wire logic [5:0] clock_minutes,
  input  wire logic [5:0] clock_seconds,
  input  wire logic [1:0] mode,
  input  wire logic       timer_running,
  output logic            LCD_EN,
  output logic            LCD_RS,
  output logic            LCD_RW,
  output logic [7:0]      LCD_DATA,
  output logic            LCD_ON,
  output logic            busy,
  output logic            frame_done
);

  localparam int PW = $clog2(PWRUP_CYC + 1);

  top_state_e    state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [5:0]    idx_q, idx_d;
  logic          issued_q, issued_d;
  logic          pend_q, pend_d;
  logic          on_q;
  snap_t         snap_q, snap_d;
  snap_t         w_live;

  logic [15:0]   w_hh, w_mm, w_ss;
  logic [31:0]   w_tag;
  logic [47:0]   w_l2;
  logic [3:0]    w_p1, w_p2;
  logic [7:0]    w_ch1, w_ch2;
  logic          w_start, w_rs, w_long;
  logic [7:0]    w_data;

  lcd_time_display_if wr_if ();

  assign wr_if.start     = w_start;
  assign wr_if.rs        = w_rs;
  assign wr_if.data      = w_data;
  assign wr_if.long_wait = w_long;

  lcd_write_engine #(
    .AS_CYC   (AS_CYC),
    .EN_CYC   (EN_CYC),
    .EXEC_CYC (EXEC_CYC),
    .CLR_CYC  (CLR_CYC)
  ) u_engine (
    .clk        (CLOCK_50),
    .rst        (reset),
    .wr         (wr_if),
    .lcd_en_o   (LCD_EN),
    .lcd_rs_o   (LCD_RS),
    .lcd_data_o (LCD_DATA)
  );

  assign LCD_RW = 1'b0;
  assign LCD_ON = on_q;

  always_comb begin
    w_live.hours   = clock_hours;
    w_live.minutes = clock_minutes;
    w_live.seconds = clock_seconds;
    w_live.mode    = mode;
    w_live.running = timer_running;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= ST_PWRUP;
      cnt_q    <= '0;
      idx_q    <= 6'd0;
      issued_q <= 1'b0;
      pend_q   <= 1'b1;
      snap_q   <= '0;
      on_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      issued_q <= issued_d;
      pend_q   <= pend_d;
      snap_q   <= snap_d;
      on_q     <= 1'b1;
    end
  end

  // Character generation: line positions are idx-1 (line 1) and idx-18 (line 2), modulo 16.
  always_comb begin
    w_hh = bin2ascii2({1'b0, snap_q.hours});
    w_mm = bin2ascii2(snap_q.minutes);
    w_ss = bin2ascii2(snap_q.seconds);
    case (snap_q.mode)
      2'd0:    w_tag = TAG_CLK;
      2'd1:    w_tag = TAG_TMR;
      2'd2:    w_tag = TAG_SET;
      default: w_tag = TAG_UNK;
    endcase
    case (snap_q.mode)
      2'd1:    w_l2 = snap_q.running ? L2_RUN : L2_STOP;
      2'd2:    w_l2 = L2_ADJ;
      default: w_l2 = L2_BLANK;
    endcase
    w_p1 = idx_q[3:0] - 4'd1;
    w_p2 = idx_q[3:0] - 4'd2;
    case (w_p1)
      4'd0:    w_ch1 = w_tag[31:24];
      4'd1:    w_ch1 = w_tag[23:16];
      4'd2:    w_ch1 = w_tag[15:8];
      4'd3:    w_ch1 = w_tag[7:0];
      4'd4:    w_ch1 = w_hh[15:8];
      4'd5:    w_ch1 = w_hh[7:0];
      4'd6:    w_ch1 = CH_COLON;
      4'd7:    w_ch1 = w_mm[15:8];
      4'd8:    w_ch1 = w_mm[7:0];
      4'd9:    w_ch1 = CH_COLON;
      4'd10:   w_ch1 = w_ss[15:8];
      4'd11:   w_ch1 = w_ss[7:0];
      default: w_ch1 = CH_SPACE;
    endcase
    case (w_p2)
      4'd0:    w_ch2 = w_l2[47:40];
      4'd1:    w_ch2 = w_l2[39:32];
      4'd2:    w_ch2 = w_l2[31:24];
      4'd3:    w_ch2 = w_l2[23:16];
      4'd4:    w_ch2 = w_l2[15:8];
      4'd5:    w_ch2 = w_l2[7:0];
      default: w_ch2 = CH_SPACE;
    endcase
  end

  always_comb begin
    w_rs   = 1'b0;
    w_data = 8'h00;
    w_long = 1'b0;
    if (state_q == ST_INIT) begin
      case (idx_q[1:0])
        2'd0:    w_data = CMD_FUNC;
        2'd1:    w_data = CMD_DISP;
        2'd2:    w_data = CMD_ENTRY;
        default: w_data = CMD_CLR;
      endcase
      w_long = (idx_q == INIT_LAST);
    end else if (idx_q == 6'd0) begin
      w_data = CMD_L1;
    end else if (idx_q <= 6'd16) begin
      w_rs   = 1'b1;
      w_data = w_ch1;
    end else if (idx_q == 6'd17) begin
      w_data = CMD_L2;
    end else begin
      w_rs   = 1'b1;
      w_data = w_ch2;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    issued_d   = issued_q;
    pend_d     = pend_q;
    snap_d     = snap_q;
    w_start    = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == PW'(PWRUP_CYC - 1)) begin
          cnt_d    = '0;
          idx_d    = 6'd0;
          issued_d = 1'b0;
          state_d  = ST_INIT;
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      ST_IDLE: begin
        busy = 1'b0;
        if ((w_live != snap_q) || pend_q) begin
          snap_d   = w_live;
          pend_d   = 1'b0;
          busy     = 1'b1;
          idx_d    = 6'd0;
          issued_d = 1'b0;
          state_d  = ST_FRAME;
        end
      end
      default: begin
        // A change during a frame only queues one more frame; the snapshot is untouched.
        if ((state_q == ST_FRAME) && (w_live != snap_q)) begin
          pend_d = 1'b1;
        end
        if (!issued_q) begin
          w_start  = 1'b1;
          issued_d = 1'b1;
        end else if (wr_if.done) begin
          issued_d = 1'b0;
          if ((state_q == ST_INIT) && (idx_q == INIT_LAST)) begin
            idx_d   = 6'd0;
            state_d = ST_IDLE;
          end else if ((state_q == ST_FRAME) && (idx_q == FRAME_LAST)) begin
            frame_done = 1'b1;
            idx_d      = 6'd0;
            state_d    = ST_IDLE;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_time_display.sv
// tb_lcd_time_display: randomized frames checked against a string-level model of the LCD byte stream.
// Revision: 1.0
`default_nettype none

module tb_lcd_time_display;

  localparam int PWRUP = 20;
  localparam int EXEC  = 10;
  localparam int CLR   = 30;
  localparam int ENC   = 4;
  localparam int ASC   = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] hh;
  logic [5:0] mm, ss;
  logic [1:0] md;
  logic       run;
  logic       LCD_EN, LCD_RS, LCD_RW, LCD_ON, busy, frame_done;
  logic [7:0] LCD_DATA;

  always #5 clk = ~clk;

  lcd_time_display #(
    .PWRUP_CYC (PWRUP),
    .AS_CYC    (ASC),
    .EN_CYC    (ENC),
    .EXEC_CYC  (EXEC),
    .CLR_CYC   (CLR)
  ) dut (
    .CLOCK_50      (clk),
    .reset         (rst),
    .clock_hours   (hh),
    .clock_minutes (mm),
    .clock_seconds (ss),
    .mode          (md),
    .timer_running (run),
    .LCD_EN        (LCD_EN),
    .LCD_RS        (LCD_RS),
    .LCD_RW        (LCD_RW),
    .LCD_DATA      (LCD_DATA),
    .LCD_ON        (LCD_ON),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  string      done_l1_q[$];
  string      done_l2_q[$];
  int         fd_cnt   = 0;
  int         en_rises = 0;
  int         fb_cnt   = 0;
  int         cur_h, cur_m, cur_s, cur_md, cur_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chks(input string name, input string act, input string req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=\"%s\" required=\"%s\"", name, act, req);
    end
  endtask

  // Reference model: render the two text lines from the display rules, then queue the byte stream.
  task automatic push_frame(input int h, input int m, input int s, input int mdv, input int r);
    string tag, l1, l2;
    case (mdv)
      0:       tag = "CLK ";
      1:       tag = "TMR ";
      2:       tag = "SET ";
      default: tag = "??? ";
    endcase
    l1 = $sformatf("%s%02d:%02d:%02d    ", tag, h, m, s);
    if (mdv == 1)      l2 = (r != 0) ? "RUN" : "STOP";
    else if (mdv == 2) l2 = "ADJUST";
    else               l2 = "";
    while (l2.len() < 16) l2 = {l2, " "};
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'(l1[i])});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'(l2[i])});
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic apply(input int h, input int m, input int s, input int mdv, input int r);
    @(negedge clk);
    #1;
    hh = 5'(h); mm = 6'(m); ss = 6'(s); md = 2'(mdv); run = 1'(r);
    cur_h = h; cur_m = m; cur_s = s; cur_md = mdv; cur_r = r;
  endtask

  task automatic wait_fd(input int target, input string name);
    int n = 0;
    while (fd_cnt < target && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, 32'(fd_cnt), 32'(target));
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_fb(input int k);
    int n = 0;
    while (fb_cnt < k && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_frame_byte actual=%0d required=%0d", fb_cnt, k);
    end
  endtask

  task automatic idle_quiet(input string name);
    int n0;
    n0 = en_rises;
    repeat (60) @(negedge clk);
    #1;
    chk({name, "_no_extra_frame"}, 32'(en_rises), 32'(n0));
    chk({name, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  // Compare process: every EN rise is checked against the model queue; RS/DATA stability,
  // RW level and the post-clear gap are checked every cycle.
  initial begin : monitor
    logic       prev_en = 1'b0;
    logic       cap_rs  = 1'b0;
    logic [7:0] cap_data = 8'h00;
    logic [8:0] e;
    int         gap = 0;
    bit         gap_armed = 0;
    int         line_sel = 0;
    string      l1s = "";
    string      l2s = "";
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en   = 1'b0;
        gap_armed = 0;
        fb_cnt    = 0;
        line_sel  = 0;
      end else begin
        chk("rw_low", 32'(LCD_RW), 32'd0);
        if (LCD_EN && !prev_en) begin
          en_rises++;
          if (gap_armed) begin
            checks++;
            if (gap < CLR) begin
              errors++;
              $display("FAIL clear_gap actual=%0d required>=%0d", gap, CLR);
            end
            gap_armed = 0;
          end
          cap_rs   = LCD_RS;
          cap_data = LCD_DATA;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h required=none", {LCD_RS, LCD_DATA});
          end else begin
            e = exp_q.pop_front();
            chk("byte", 32'({LCD_RS, LCD_DATA}), 32'(e));
          end
          if (!LCD_RS && LCD_DATA == 8'h80) begin
            line_sel = 1; l1s = ""; l2s = ""; fb_cnt = 1;
          end else begin
            if (fb_cnt > 0) fb_cnt++;
            if (!LCD_RS && LCD_DATA == 8'hC0) line_sel = 2;
            else if (LCD_RS && line_sel == 1) l1s = $sformatf("%s%c", l1s, LCD_DATA);
            else if (LCD_RS && line_sel == 2) l2s = $sformatf("%s%c", l2s, LCD_DATA);
          end
        end else if (prev_en) begin
          chk("rs_data_stable", 32'({LCD_RS, LCD_DATA}), 32'({cap_rs, cap_data}));
          if (!LCD_EN && !cap_rs && cap_data == 8'h01) begin
            gap_armed = 1;
            gap = 0;
          end
        end
        if (gap_armed && !LCD_EN) gap++;
        if (frame_done) begin
          fd_cnt++;
          fb_cnt = 0;
          done_l1_q.push_back(l1s);
          done_l2_q.push_back(l2s);
        end
        prev_en = LCD_EN;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base, h, m, s, mv, r, k;
    rst = 1'b1;
    hh = 5'd11; mm = 6'd2; ss = 6'd1; md = 2'd0; run = 1'b0;
    cur_h = 11; cur_m = 2; cur_s = 1; cur_md = 0; cur_r = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", 32'(LCD_EN), 32'd0);
    chk("rst_rs", 32'(LCD_RS), 32'd0);
    chk("rst_data", 32'(LCD_DATA), 32'd0);
    chk("rst_on", 32'(LCD_ON), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_frame_done", 32'(frame_done), 32'd0);

    push_init();
    push_frame(11, 2, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("lcd_on_after_release", 32'(LCD_ON), 32'd1);
    wait_fd(1, "first_frame");
    chks("line1_clk", done_l1_q[$], "CLK 11:02:01    ");
    chks("line2_blank", done_l2_q[$], "                ");
    idle_quiet("after_first");

    apply(11, 2, 2, 0, 0);
    push_frame(11, 2, 2, 0, 0);
    wait_fd(2, "seconds_change");
    chks("line1_sec2", done_l1_q[$], "CLK 11:02:02    ");
    idle_quiet("after_sec");

    apply(11, 2, 2, 1, 1);
    push_frame(11, 2, 2, 1, 1);
    wait_fb(5);
    apply(11, 2, 2, 1, 0);
    push_frame(11, 2, 2, 1, 0);
    wait_fd(4, "midframe_pair");
    chks("line2_run", done_l2_q[done_l2_q.size()-2], "RUN             ");
    chks("line2_stop", done_l2_q[$], "STOP            ");
    idle_quiet("after_pair");

    apply(31, 63, 2, 0, 0);
    push_frame(31, 63, 2, 0, 0);
    wait_fd(5, "out_of_range");
    chks("line1_noclamp", done_l1_q[$], "CLK 31:63:02    ");

    for (int it = 0; it < 10; it++) begin
      h = int'($urandom_range(31, 0));
      m = int'($urandom_range(63, 0));
      s = int'($urandom_range(63, 0));
      mv = int'($urandom_range(3, 0));
      r = int'($urandom_range(1, 0));
      if (h == cur_h && m == cur_m && s == cur_s && mv == cur_md && r == cur_r) s = (s + 1) % 64;
      base = fd_cnt;
      apply(h, m, s, mv, r);
      push_frame(h, m, s, mv, r);
      if ($urandom_range(1, 0) == 1) begin
        k = int'($urandom_range(30, 2));
        wait_fb(k);
        s = (s + 1) % 64;
        apply(h, m, s, mv, r);
        push_frame(h, m, s, mv, r);
        wait_fd(base + 2, "rand_pair");
      end else begin
        wait_fd(base + 1, "rand_frame");
      end
      idle_quiet("rand");
    end

    apply(23, 59, 58, 2, 0);
    push_frame(23, 59, 58, 2, 0);
    wait_fb(10);
    while (!LCD_EN) begin
      @(negedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midwrite_reset_en", 32'(LCD_EN), 32'd0);
    chk("midwrite_reset_busy", 32'(busy), 32'd1);
    chk("midwrite_reset_on", 32'(LCD_ON), 32'd0);
    exp_q.delete();
    base = fd_cnt;
    push_init();
    push_frame(23, 59, 58, 2, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("lcd_on_after_rerelease", 32'(LCD_ON), 32'd1);
    wait_fd(base + 1, "reinit_frame");
    chks("line1_set", done_l1_q[$], "SET 23:59:58    ");
    chks("line2_adjust", done_l2_q[$], "ADJUST          ");
    idle_quiet("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
